// File: rtl/anti_theft_ctrl.sv
// Vehicle anti-theft controller: arm/trigger/alarm sequencing with a
// one-second countdown timer fed by an external time-parameter block.
// The parameter block registers 'value' one clock after 'interval' changes.
// For that reason 'interval' shows the newly selected parameter in the
// same clock the transition is decided. The counter can then load the
// matching delay on the clock after the state change.
module anti_theft_ctrl (
   input  logic       clock,
   input  logic       reset,
   input  logic       ignition,
   input  logic       door_driver,
   input  logic       door_pass,
   input  logic       reprogram,
   input  logic       one_hz_enable,
   input  logic [3:0] value,
   output logic [1:0] interval,
   output logic       siren,
   output logic       status,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      ARMED      = 3'b000,
      TRIGGERED  = 3'b001,
      ALARM      = 3'b010,
      DISARMED   = 3'b011,
      WAIT_DOOR  = 3'b100,
      WAIT_CLOSE = 3'b101,
      ARM_DELAY  = 3'b110,
      UNUSED     = 3'b111
   } state_t;

   localparam logic [1:0] SEL_ARM    = 2'b00;
   localparam logic [1:0] SEL_DRIVER = 2'b01;
   localparam logic [1:0] SEL_PASS   = 2'b10;
   localparam logic [1:0] SEL_ALARM  = 2'b11;

   state_t     state;
   state_t     state_next;
   logic [1:0] interval_reg;
   logic [1:0] interval_next;
   logic [3:0] counter;
   logic       load_pending;
   logic       start_timer;
   logic       door_open;
   logic       timed;
   logic       expired;

   // Timer status: expiry is only meaningful once the delay has been loaded
   always_comb begin
      door_open = door_driver | door_pass;
      timed     = (state == TRIGGERED) || (state == ALARM) || (state == ARM_DELAY);
      expired   = timed && !load_pending && (counter == 4'd0);
   end

   // Next-state, parameter select and timer-start decision
   always_comb begin
      state_next    = state;
      interval_next = interval_reg;
      start_timer   = 1'b0;
      if (reprogram) begin
         state_next    = ARMED;
         interval_next = SEL_ARM;
      end else begin
         case (state)
            ARMED: begin
               if (ignition) begin
                  state_next = DISARMED;
               end else if (door_driver) begin
                  state_next    = TRIGGERED;
                  interval_next = SEL_DRIVER;
                  start_timer   = 1'b1;
               end else if (door_pass) begin
                  state_next    = TRIGGERED;
                  interval_next = SEL_PASS;
                  start_timer   = 1'b1;
               end
            end
            TRIGGERED: begin
               if (ignition) begin
                  state_next = DISARMED;
               end else if (expired) begin
                  state_next    = ALARM;
                  interval_next = SEL_ALARM;
                  start_timer   = 1'b1;
               end
            end
            ALARM: begin
               if (ignition) begin
                  state_next = DISARMED;
               end else if (expired) begin
                  state_next = ARMED;
               end
            end
            DISARMED: begin
               if (!ignition) begin
                  state_next = WAIT_DOOR;
               end
            end
            WAIT_DOOR: begin
               if (door_driver) begin
                  state_next = WAIT_CLOSE;
               end else if (ignition) begin
                  state_next = DISARMED;
               end
            end
            WAIT_CLOSE: begin
               // Ignition wins so a driver starting the car never begins arming
               if (ignition) begin
                  state_next = DISARMED;
               end else if (!door_open) begin
                  state_next    = ARM_DELAY;
                  interval_next = SEL_ARM;
                  start_timer   = 1'b1;
               end
            end
            ARM_DELAY: begin
               if (door_open) begin
                  state_next = WAIT_CLOSE;
               end else if (ignition) begin
                  state_next = DISARMED;
               end else if (expired) begin
                  state_next = ARMED;
               end
            end
            default: begin
               state_next = ARMED;
            end
         endcase
      end
   end

   // Parameter select is forced to the arm delay while reset is held
   always_comb begin
      interval = reset ? interval_next : SEL_ARM;
   end

   assign fsm_state = state;

   // State and parameter-select registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= ARMED;
         interval_reg <= SEL_ARM;
      end else begin
         state        <= state_next;
         interval_reg <= interval_next;
      end
   end

   // Countdown timer: load one clock after a start, frozen while an alarm door is open
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         counter      <= 4'd0;
         load_pending <= 1'b0;
      end else if (reprogram) begin
         counter      <= 4'd0;
         load_pending <= 1'b0;
      end else if (start_timer) begin
         load_pending <= 1'b1;
      end else if ((state == ALARM) && door_open) begin
         counter      <= value;
         load_pending <= 1'b1;
      end else if (load_pending) begin
         counter      <= value;
         load_pending <= 1'b0;
      end else if (one_hz_enable && (counter != 4'd0)) begin
         counter <= counter - 4'd1;
      end
   end

   // Registered siren and status LED, derived from the state being entered
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         siren  <= 1'b0;
         status <= 1'b0;
      end else begin
         siren <= (state_next == ALARM);
         case (state_next)
            ARMED:           status <= (state == ARMED) ? (status ^ one_hz_enable) : 1'b0;
            TRIGGERED, ALARM: status <= 1'b1;
            default:         status <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_anti_theft_ctrl.sv
// Testbench for anti_theft_ctrl: a table of single-clock vectors checked
// through a scoreboard queue, plus multi-cycle countdown scenarios.
// The bench also models the external time-parameter block.
module tb_anti_theft_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       ignition = 1'b0;
   logic       door_driver = 1'b0;
   logic       door_pass = 1'b0;
   logic       reprogram = 1'b0;
   logic       one_hz_enable = 1'b0;
   logic [3:0] value = 4'd0;
   logic [1:0] interval;
   logic       siren;
   logic       status;
   logic [2:0] fsm_state;

   logic [3:0] param_arm = 4'd6;
   logic [3:0] param_driver = 4'd8;
   logic [3:0] param_pass = 4'd15;
   logic [3:0] param_alarm = 4'd10;

   int compare_count = 0;
   int mismatch_count = 0;
   int siren_count = 0;
   int siren_base;

   localparam logic [2:0] S_ARMED = 3'b000;
   localparam logic [2:0] S_TRIG  = 3'b001;
   localparam logic [2:0] S_ALARM = 3'b010;
   localparam logic [2:0] S_DIS   = 3'b011;
   localparam logic [2:0] S_WDOOR = 3'b100;
   localparam logic [2:0] S_WCLS  = 3'b101;
   localparam logic [2:0] S_ADLY  = 3'b110;

   typedef struct {
      string      name;
      logic       ign;
      logic       dd;
      logic       dp;
      logic       rp;
      logic       tick;
      logic [2:0] st;
      logic [1:0] iv;
      logic       sir;
      logic       sta;
   } vec_t;

   typedef struct {
      string      name;
      logic [2:0] st;
      logic [1:0] iv;
      logic       sir;
      logic       sta;
   } exp_t;

   vec_t vecs[$];
   exp_t expq[$];

   anti_theft_ctrl dut (
      .clock(clock),
      .reset(reset),
      .ignition(ignition),
      .door_driver(door_driver),
      .door_pass(door_pass),
      .reprogram(reprogram),
      .one_hz_enable(one_hz_enable),
      .value(value),
      .interval(interval),
      .siren(siren),
      .status(status),
      .fsm_state(fsm_state)
   );

   always #5 clock = ~clock;

   // Time-parameter block model: value registered one clock after interval
   always @(posedge clock) begin
      case (interval)
         2'b00:   value <= param_arm;
         2'b01:   value <= param_driver;
         2'b10:   value <= param_pass;
         default: value <= param_alarm;
      endcase
   end

   // Counts clocks on which the siren is seen on
   always @(negedge clock) begin
      if (siren === 1'b1) siren_count = siren_count + 1;
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
      compare_count++;
      if (act !== expv) begin
         mismatch_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      exp_t e;
      ignition      = v.ign;
      door_driver   = v.dd;
      door_pass     = v.dp;
      reprogram     = v.rp;
      one_hz_enable = v.tick;
      e.name = v.name;
      e.st   = v.st;
      e.iv   = v.iv;
      e.sir  = v.sir;
      e.sta  = v.sta;
      expq.push_back(e);
   endtask

   task automatic popAndCheck();
      exp_t e;
      if (expq.size() == 0) begin
         checkOutput("scoreboard_empty", 8'd1, 8'd0);
      end else begin
         e = expq.pop_front();
         checkOutput({e.name, "_state"}, {5'd0, fsm_state}, {5'd0, e.st});
         checkOutput({e.name, "_interval"}, {6'd0, interval}, {6'd0, e.iv});
         checkOutput({e.name, "_siren"}, {7'd0, siren}, {7'd0, e.sir});
         checkOutput({e.name, "_status"}, {7'd0, status}, {7'd0, e.sta});
      end
   endtask

   task automatic addVec(input string n, input logic [4:0] in, input logic [2:0] st,
                         input logic [1:0] iv, input logic sir, input logic sta);
      vec_t v;
      v.name = n;
      {v.ign, v.dd, v.dp, v.rp, v.tick} = in;
      v.st  = st;
      v.iv  = iv;
      v.sir = sir;
      v.sta = sta;
      vecs.push_back(v);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b0;
      ignition = 1'b0;
      door_driver = 1'b0;
      door_pass = 1'b0;
      reprogram = 1'b0;
      one_hz_enable = 1'b0;
      #2;
      checkOutput("rst_state", {5'd0, fsm_state}, 8'd0);
      checkOutput("rst_interval", {6'd0, interval}, 8'd0);
      checkOutput("rst_siren", {7'd0, siren}, 8'd0);
      checkOutput("rst_status", {7'd0, status}, 8'd0);
      checkOutput("rst_counter", {4'd0, dut.counter}, 8'd0);
      checkOutput("rst_load_pending", {7'd0, dut.load_pending}, 8'd0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // One one-second pulse, then two idle clocks; called and returns on a falling edge
   task automatic tick(input int n);
      repeat (n) begin
         one_hz_enable = 1'b1;
         @(negedge clock);
         one_hz_enable = 1'b0;
         @(negedge clock);
         @(negedge clock);
      end
   endtask

   task automatic chkState(input string n, input logic [2:0] st);
      checkOutput(n, {5'd0, fsm_state}, {5'd0, st});
   endtask

   task automatic chkCounter(input string n, input logic [3:0] c);
      checkOutput(n, {4'd0, dut.counter}, {4'd0, c});
   endtask

   // Global watchdog so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // inputs {ign, dd, dp, rp, tick}
      addVec("v01_ign_disarm",    5'b10000, S_DIS,   2'b00, 1'b0, 1'b0);
      addVec("v02_ign_off",       5'b00000, S_WDOOR, 2'b00, 1'b0, 1'b0);
      addVec("v03_driver_open",   5'b01000, S_WCLS,  2'b00, 1'b0, 1'b0);
      addVec("v04_ign_in_wclose", 5'b11000, S_DIS,   2'b00, 1'b0, 1'b0);
      addVec("v05_ign_off",       5'b01000, S_WDOOR, 2'b00, 1'b0, 1'b0);
      addVec("v06_driver_open",   5'b01000, S_WCLS,  2'b00, 1'b0, 1'b0);
      addVec("v07_doors_closed",  5'b00000, S_ADLY,  2'b00, 1'b0, 1'b0);
      addVec("v08_pass_reopen",   5'b00100, S_WCLS,  2'b00, 1'b0, 1'b0);
      addVec("v09_doors_closed",  5'b00000, S_ADLY,  2'b00, 1'b0, 1'b0);
      addVec("v10_ign_in_adelay", 5'b10000, S_DIS,   2'b00, 1'b0, 1'b0);
      addVec("v11_ign_off",       5'b00000, S_WDOOR, 2'b00, 1'b0, 1'b0);
      addVec("v12_ign_in_wdoor",  5'b10000, S_DIS,   2'b00, 1'b0, 1'b0);
      addVec("v13_reprogram",     5'b00010, S_ARMED, 2'b00, 1'b0, 1'b0);
      addVec("v14_armed_tick",    5'b00001, S_ARMED, 2'b00, 1'b0, 1'b1);
      addVec("v15_both_doors",    5'b01100, S_TRIG,  2'b01, 1'b0, 1'b1);
      addVec("v16_reprogram",     5'b00010, S_ARMED, 2'b00, 1'b0, 1'b0);
      addVec("v17_pass_door",     5'b00100, S_TRIG,  2'b10, 1'b0, 1'b1);
      addVec("v18_ign_in_trig",   5'b10000, S_DIS,   2'b10, 1'b0, 1'b0);
      addVec("v19_ign_off",       5'b00000, S_WDOOR, 2'b10, 1'b0, 1'b0);

      $display("[TB] vector table");
      doReset();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clock);
         popAndCheck();
      end

      $display("[TB] driver door to alarm");
      doReset();
      door_driver = 1'b1;
      @(negedge clock);
      chkState("a_trig_state", S_TRIG);
      checkOutput("a_trig_interval", {6'd0, interval}, 8'h01);
      door_driver = 1'b0;
      @(negedge clock);
      chkCounter("a_loaded_8", 4'd8);
      tick(7);
      chkState("a_still_trig", S_TRIG);
      chkCounter("a_counter_1", 4'd1);
      tick(1);
      chkState("a_alarm_state", S_ALARM);
      checkOutput("a_alarm_siren", {7'd0, siren}, 8'h01);
      checkOutput("a_alarm_interval", {6'd0, interval}, 8'h03);
      checkOutput("a_alarm_status", {7'd0, status}, 8'h01);

      $display("[TB] alarm frozen by open door");
      doReset();
      door_pass = 1'b1;
      @(negedge clock);
      chkState("b_trig_state", S_TRIG);
      checkOutput("b_trig_interval", {6'd0, interval}, 8'h02);
      @(negedge clock);
      chkCounter("b_loaded_15", 4'd15);
      tick(15);
      chkState("b_alarm_state", S_ALARM);
      tick(20);
      chkState("b_frozen_state", S_ALARM);
      chkCounter("b_frozen_counter", 4'd10);
      checkOutput("b_frozen_pending", {7'd0, dut.load_pending}, 8'h01);
      door_pass = 1'b0;
      @(negedge clock);
      tick(9);
      chkState("b_9_ticks_alarm", S_ALARM);
      checkOutput("b_9_ticks_siren", {7'd0, siren}, 8'h01);
      tick(1);
      chkState("b_10_ticks_armed", S_ARMED);
      checkOutput("b_armed_siren", {7'd0, siren}, 8'h00);
      checkOutput("b_armed_status", {7'd0, status}, 8'h00);

      $display("[TB] ignition during trigger");
      doReset();
      siren_base = siren_count;
      door_pass = 1'b1;
      @(negedge clock);
      chkState("c_trig_state", S_TRIG);
      tick(4);
      ignition = 1'b1;
      @(negedge clock);
      chkState("c_disarmed", S_DIS);
      ignition = 1'b0;
      door_pass = 1'b0;
      @(negedge clock);
      chkState("c_wait_door", S_WDOOR);
      checkOutput("c_siren_never", siren_count - siren_base, 0);

      $display("[TB] arm delay restart");
      doReset();
      ignition = 1'b1;
      @(negedge clock);
      ignition = 1'b0;
      @(negedge clock);
      door_driver = 1'b1;
      @(negedge clock);
      chkState("d_wait_close", S_WCLS);
      door_driver = 1'b0;
      @(negedge clock);
      chkState("d_arm_delay", S_ADLY);
      checkOutput("d_interval", {6'd0, interval}, 8'h00);
      @(negedge clock);
      chkCounter("d_loaded_6", 4'd6);
      tick(3);
      chkCounter("d_counter_3", 4'd3);
      door_driver = 1'b1;
      @(negedge clock);
      chkState("d_reopen", S_WCLS);
      door_driver = 1'b0;
      @(negedge clock);
      chkState("d_arm_delay2", S_ADLY);
      @(negedge clock);
      chkCounter("d_reloaded_6", 4'd6);
      tick(5);
      chkState("d_5_ticks", S_ADLY);
      tick(1);
      chkState("d_armed", S_ARMED);

      $display("[TB] reprogram during trigger");
      doReset();
      door_driver = 1'b1;
      @(negedge clock);
      door_driver = 1'b0;
      @(negedge clock);
      tick(2);
      chkCounter("e_counter_6", 4'd6);
      reprogram = 1'b1;
      @(negedge clock);
      chkState("e_reprog_state", S_ARMED);
      chkCounter("e_reprog_counter", 4'd0);
      checkOutput("e_reprog_pending", {7'd0, dut.load_pending}, 8'h00);
      checkOutput("e_reprog_siren", {7'd0, siren}, 8'h00);
      reprogram = 1'b0;
      @(negedge clock);
      chkState("e_stays_armed", S_ARMED);

      $display("[TB] zero delay and async reset");
      param_driver = 4'd0;
      doReset();
      door_driver = 1'b1;
      @(negedge clock);
      chkState("f_trig", S_TRIG);
      door_driver = 1'b0;
      @(negedge clock);
      chkState("f_loaded_zero", S_TRIG);
      chkCounter("f_counter_0", 4'd0);
      @(negedge clock);
      chkState("f_alarm", S_ALARM);
      checkOutput("f_alarm_siren", {7'd0, siren}, 8'h01);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("f_async_siren", {7'd0, siren}, 8'h00);
      checkOutput("f_async_state", {5'd0, fsm_state}, 8'h00);
      checkOutput("f_async_interval", {6'd0, interval}, 8'h00);
      checkOutput("f_async_status", {7'd0, status}, 8'h00);
      @(negedge clock);
      reset = 1'b1;
      param_driver = 4'd8;
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
